// File: rtl/sa_ctrl_pkg.sv
// Shared types and width/length helpers for the systolic-array feed scheduler.
package sa_ctrl_pkg;

   typedef enum logic [1:0] {
      SA_IDLE  = 2'd0,
      SA_FEED  = 2'd1,
      SA_DRAIN = 2'd2,
      SA_DONE  = 2'd3
   } sa_state_e;

   function automatic int unsigned sa_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to count 0..v-1, never less than one bit.
   function automatic int unsigned sa_clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int unsigned sa_kw(input int unsigned k_max);
      return sa_clog2_min1(k_max + 1);
   endfunction

   function automatic int unsigned sa_aw(input int unsigned k_max);
      return sa_clog2_min1(k_max);
   endfunction

   function automatic int unsigned sa_drain_cycles(input int unsigned buf_lat,
                                                   input int unsigned mac_latency,
                                                   input int unsigned rows,
                                                   input int unsigned cols);
      return buf_lat + mac_latency + rows + cols - 2;
   endfunction

   // Counter must cover both the longest FEED phase and the DRAIN phase.
   function automatic int unsigned sa_cnt_width(input int unsigned k_max,
                                                input int unsigned rows,
                                                input int unsigned cols,
                                                input int unsigned buf_lat,
                                                input int unsigned mac_latency);
      int unsigned feed_max;
      feed_max = k_max + sa_max(rows, cols) - 1;
      return sa_clog2_min1(sa_max(feed_max, sa_drain_cycles(buf_lat, mac_latency, rows, cols)));
   endfunction

endpackage

// File: rtl/sa_valid_delay.sv
// N-bit, DEPTH-deep valid delay line with synchronous clear.
module sa_valid_delay #(
   parameter int unsigned N     = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else if (clr_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sa_feed_scheduler.sv
// Sequences one tile through the systolic array: skewed edge-buffer reads,
// delayed edge valids, fixed drain, then a one-cycle done pulse.
module sa_feed_scheduler
   import sa_ctrl_pkg::*;
#(
   parameter int unsigned ROWS        = 16,
   parameter int unsigned COLS        = 16,
   parameter int unsigned K_MAX       = 256,
   parameter int unsigned BUF_LAT     = 1,
   parameter int unsigned MAC_LATENCY = 8,
   localparam int unsigned KW         = sa_kw(K_MAX),
   localparam int unsigned AW         = sa_aw(K_MAX)
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [KW-1:0]        cmd_k_i,
   input  logic                 abort_i,
   output logic [ROWS-1:0]      in_rd_en_o,
   output logic [ROWS*AW-1:0]   in_rd_addr_o,
   output logic [COLS-1:0]      w_rd_en_o,
   output logic [COLS*AW-1:0]   w_rd_addr_o,
   output logic [ROWS-1:0]      in_valid_o,
   output logic [COLS-1:0]      w_valid_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned MAXRC = sa_max(ROWS, COLS);
   localparam int unsigned DRAIN = sa_drain_cycles(BUF_LAT, MAC_LATENCY, ROWS, COLS);
   localparam int unsigned CW    = sa_cnt_width(K_MAX, ROWS, COLS, BUF_LAT, MAC_LATENCY);

   sa_state_e           state_q, state_d;
   logic [CW-1:0]       t_q, t_d;
   logic [KW-1:0]       k_q, k_d;
   logic [KW-1:0]       k_clamp;
   logic [CW:0]         feed_last;

   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ROWS-1:0]     in_en_q, in_en_d;
   logic [ROWS*AW-1:0]  in_addr_q, in_addr_d;
   logic [COLS-1:0]     w_en_q, w_en_d;
   logic [COLS*AW-1:0]  w_addr_q, w_addr_d;
   logic                vclr;

   // Lane idx reads in step t when idx <= t < idx + k.
   function automatic logic in_window(input logic [CW-1:0] t, input int unsigned idx,
                                      input logic [KW-1:0] k);
      logic [CW:0] lo;
      lo = (CW+1)'(idx);
      return ({1'b0, t} >= lo) && ({1'b0, t} < lo + (CW+1)'(k));
   endfunction

   assign k_clamp   = (cmd_k_i > KW'(K_MAX)) ? KW'(K_MAX) : cmd_k_i;
   assign feed_last = (CW+1)'(k_q) + (CW+1)'(MAXRC - 1) - (CW+1)'(1);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SA_IDLE;
         t_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      k_d     = k_q;
      unique case (state_q)
         SA_IDLE: begin
            if (cmd_valid_i) begin
               k_d     = k_clamp;
               t_d     = '0;
               state_d = (k_clamp != '0) ? SA_FEED : SA_DONE;
            end
         end
         SA_FEED: begin
            if (abort_i) begin
               state_d = SA_IDLE;
            end else if ({1'b0, t_q} == feed_last) begin
               state_d = SA_DRAIN;
               t_d     = '0;
            end else begin
               t_d = t_q + CW'(1);
            end
         end
         SA_DRAIN: begin
            if (abort_i) begin
               state_d = SA_IDLE;
            end else if (t_q == CW'(DRAIN - 1)) begin
               state_d = SA_DONE;
               t_d     = '0;
            end else begin
               t_d = t_q + CW'(1);
            end
         end
         SA_DONE: state_d = SA_IDLE;
         default: state_d = SA_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      ready_d   = (state_d == SA_IDLE);
      busy_d    = (state_d != SA_IDLE);
      done_d    = (state_d == SA_DONE);
      in_en_d   = '0;
      in_addr_d = '0;
      w_en_d    = '0;
      w_addr_d  = '0;
      if (state_d == SA_FEED) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            if (in_window(t_d, r, k_d)) begin
               in_en_d[r]             = 1'b1;
               in_addr_d[r*AW +: AW]  = AW'(t_d - CW'(r));
            end
         end
         for (int unsigned c = 0; c < COLS; c++) begin
            if (in_window(t_d, c, k_d)) begin
               w_en_d[c]              = 1'b1;
               w_addr_d[c*AW +: AW]   = AW'(t_d - CW'(c));
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         in_en_q   <= '0;
         in_addr_q <= '0;
         w_en_q    <= '0;
         w_addr_q  <= '0;
      end else begin
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         in_en_q   <= in_en_d;
         in_addr_q <= in_addr_d;
         w_en_q    <= w_en_d;
         w_addr_q  <= w_addr_d;
      end
   end

   assign vclr = abort_i && (state_q != SA_IDLE);

   sa_valid_delay #(.N(ROWS), .DEPTH(BUF_LAT)) u_in_vdly (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr_i (vclr),
      .d_i   (in_en_q),
      .q_o   (in_valid_o)
   );

   sa_valid_delay #(.N(COLS), .DEPTH(BUF_LAT)) u_w_vdly (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr_i (vclr),
      .d_i   (w_en_q),
      .q_o   (w_valid_o)
   );

   assign cmd_ready_o  = ready_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign in_rd_en_o   = in_en_q;
   assign in_rd_addr_o = in_addr_q;
   assign w_rd_en_o    = w_en_q;
   assign w_rd_addr_o  = w_addr_q;

endmodule

// File: tb/tb_sa_feed_scheduler.sv
// Scoreboard bench: each tile pushes its expected per-cycle output trace,
// monitors pop and compare every cycle for two array configurations.
module tb_sa_feed_scheduler;

   typedef struct packed {
      logic        rdy;
      logic        busy;
      logic        done;
      logic [3:0]  in_en;
      logic [3:0]  w_en;
      logic [3:0]  in_v;
      logic [3:0]  w_v;
      logic [11:0] in_addr;
      logic [11:0] w_addr;
   } snap_t;

   logic clk;
   logic rst_n;

   logic        a_cmd_valid, a_rdy, a_abort, a_busy, a_done;
   logic [3:0]  a_cmd_k, a_in_en, a_w_en, a_in_v, a_w_v;
   logic [11:0] a_in_addr, a_w_addr;

   logic        b_cmd_valid, b_rdy, b_abort, b_busy, b_done;
   logic [3:0]  b_cmd_k, b_in_en, b_in_v;
   logic [1:0]  b_w_en, b_w_v;
   logic [11:0] b_in_addr;
   logic [5:0]  b_w_addr;

   int checks   = 0;
   int failures = 0;
   snap_t qa[$];
   snap_t qb[$];
   snap_t idle_s;
   int a_n, a_done_at;

   sa_feed_scheduler #(.ROWS(4), .COLS(4), .K_MAX(8), .BUF_LAT(1), .MAC_LATENCY(5)) dut_a (
      .clk_i(clk), .rst_n(rst_n), .cmd_valid_i(a_cmd_valid), .cmd_ready_o(a_rdy),
      .cmd_k_i(a_cmd_k), .abort_i(a_abort), .in_rd_en_o(a_in_en), .in_rd_addr_o(a_in_addr),
      .w_rd_en_o(a_w_en), .w_rd_addr_o(a_w_addr), .in_valid_o(a_in_v), .w_valid_o(a_w_v),
      .busy_o(a_busy), .done_o(a_done));

   sa_feed_scheduler #(.ROWS(4), .COLS(2), .K_MAX(8), .BUF_LAT(2), .MAC_LATENCY(3)) dut_b (
      .clk_i(clk), .rst_n(rst_n), .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_rdy),
      .cmd_k_i(b_cmd_k), .abort_i(b_abort), .in_rd_en_o(b_in_en), .in_rd_addr_o(b_in_addr),
      .w_rd_en_o(b_w_en), .w_rd_addr_o(b_w_addr), .in_valid_o(b_in_v), .w_valid_o(b_w_v),
      .busy_o(b_busy), .done_o(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic snap_t get_a();
      return {a_rdy, a_busy, a_done, a_in_en, a_w_en, a_in_v, a_w_v, a_in_addr, a_w_addr};
   endfunction

   function automatic snap_t get_b();
      return {b_rdy, b_busy, b_done, b_in_en, 2'b00, b_w_en, b_in_v, 2'b00, b_w_v,
              b_in_addr, 6'd0, b_w_addr};
   endfunction

   // Expected outputs in cycle n after a handshake at edge 0 (ab: abort cycle, 0 = none).
   function automatic snap_t exp_snap(int n, int k, int rows, int cols, int bl, int ml, int ab);
      snap_t s;
      int f, d, last, mx, t;
      s = '0;
      mx = (rows > cols) ? rows : cols;
      f = k + mx - 1;
      d = bl + ml + rows + cols - 2;
      last = (k == 0) ? 1 : f + d + 1;
      if ((ab != 0 && n > ab) || n > last) begin
         s.rdy = 1'b1;
         return s;
      end
      s.busy = 1'b1;
      s.done = (n == last);
      if (k > 0) begin
         for (int r = 0; r < rows; r++) begin
            t = n - 1;
            if (n <= f && t >= r && t < r + k) begin
               s.in_en[r] = 1'b1;
               s.in_addr[r*3 +: 3] = 3'(t - r);
            end
            t = n - bl - 1;
            if (t >= 0 && t < f && t >= r && t < r + k) s.in_v[r] = 1'b1;
         end
         for (int c = 0; c < cols; c++) begin
            t = n - 1;
            if (n <= f && t >= c && t < c + k) begin
               s.w_en[c] = 1'b1;
               s.w_addr[c*3 +: 3] = 3'(t - c);
            end
            t = n - bl - 1;
            if (t >= 0 && t < f && t >= c && t < c + k) s.w_v[c] = 1'b1;
         end
      end
      return s;
   endfunction

   task automatic check_snap(input string name, input snap_t got, input snap_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Monitors: one pop per cycle, idle expected when nothing is queued.
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            a_n++;
         end else begin
            e = idle_s;
         end
         if (a_done === 1'b1 && a_done_at == 0) a_done_at = a_n;
         check_snap("dut_a_cycle", get_a(), e);
      end
   end

   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qb.size() > 0) e = qb.pop_front();
         else e = idle_s;
         check_snap("dut_b_cycle", get_b(), e);
      end
   end

   // Issue one tile; rst_at > 0 asserts rst_n in that cycle and discards the rest.
   task automatic run_tile(input bit sel, input int k_cmd, input int ab, input int rst_at);
      int k, f, d, last, len, rows, cols, bl, ml, mx;
      @(negedge clk);
      checks++;
      if ((sel ? b_rdy : a_rdy) !== 1'b1) begin
         failures++;
         $display("FAIL cmd_ready_before_cmd got=%b exp=1", sel ? b_rdy : a_rdy);
      end
      rows = 4; cols = sel ? 2 : 4; bl = sel ? 2 : 1; ml = sel ? 3 : 5;
      k = (k_cmd > 8) ? 8 : k_cmd;
      mx = (rows > cols) ? rows : cols;
      f = k + mx - 1;
      d = bl + ml + rows + cols - 2;
      last = (k == 0) ? 1 : f + d + 1;
      len = (ab != 0 && ab < last) ? ab + 1 : last + 1;
      for (int n = 1; n <= len; n++) begin
         if (sel) qb.push_back(exp_snap(n, k, rows, cols, bl, ml, ab));
         else     qa.push_back(exp_snap(n, k, rows, cols, bl, ml, ab));
      end
      a_n = 0;
      a_done_at = 0;
      if (sel) begin b_cmd_valid = 1'b1; b_cmd_k = 4'(k_cmd); end
      else     begin a_cmd_valid = 1'b1; a_cmd_k = 4'(k_cmd); end
      @(negedge clk);
      a_cmd_valid = 1'b0;
      b_cmd_valid = 1'b0;
      for (int n = 1; n <= len + 1; n++) begin
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_snap("async_reset_a", get_a(), idle_s);
            check_snap("async_reset_b", get_b(), idle_s);
            qa.delete();
            qb.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         a_abort = (!sel && n == ab);
         b_abort = (sel && n == ab);
         @(negedge clk);
      end
      a_abort = 1'b0;
      b_abort = 1'b0;
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   initial begin
      idle_s = '0;
      idle_s.rdy = 1'b1;
      a_n = 0; a_done_at = 0;
      rst_n = 1'b0;
      a_cmd_valid = 1'b0; a_cmd_k = '0; a_abort = 1'b0;
      b_cmd_valid = 1'b0; b_cmd_k = '0; b_abort = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_tile(1'b0, 3, 0, 0);                 // K=3: F=6, D=12, done in cycle 19
      check_int("k3_done_cycle", a_done_at, 19);
      run_tile(1'b0, 0, 0, 0);                 // K=0: done in cycle 1 only
      check_int("k0_done_cycle", a_done_at, 1);
      run_tile(1'b0, 13, 0, 0);                // clamped to K_MAX=8, F=11
      check_int("kclamp_done_cycle", a_done_at, 24);
      run_tile(1'b0, 3, 4, 0);                 // abort in FEED
      check_int("abort_no_done", a_done_at, 0);
      run_tile(1'b1, 2, 0, 0);                 // 4x2, F=5
      run_tile(1'b1, 5, 10, 0);                // abort in DRAIN with BUF_LAT=2
      run_tile(1'b0, 3, 0, 10);                // reset mid-DRAIN
      run_tile(1'b0, 2, 0, 0);
      run_tile(1'b0, 1, 0, 0);
      run_tile(1'b1, 8, 0, 0);
      run_tile(1'b0, 8, 3, 0);                 // abort early in a long tile
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sa_feed_scheduler.md
# sa_feed_scheduler

Sequences one matrix tile through the ROWS×COLS systolic array of floating-point MAC PEs. It accepts a tile command (reduction length K) over a valid/ready handshake. It then generates diagonally skewed read enables and addresses for the per-row input buffers and per-column weight buffers, and the matching delayed valid strobes that enter the array edges. It waits a fixed drain interval for the pipelined MACs and the array wavefront to empty, then pulses `done_o`. It sits between the tile-level control and the array edge buffers.

## Interface
- `ROWS`, 16: array rows; one input buffer per row.
- `COLS`, 16: array columns; one weight buffer per column.
- `K_MAX`, 256: maximum reduction length, and the depth of each buffer.
- `BUF_LAT`, 1: edge-buffer read latency in cycles (≥1).
- `MAC_LATENCY`, 8: latency of the pipelined MAC inside each PE.
- `clk_i`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `cmd_valid_i`  in  1  tile command valid.
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_k_i`  in  KW=$clog2(K_MAX+1)  reduction length K.
- `abort_i`  in  1  synchronous abort of the current tile.
- `in_rd_en_o`  out  ROWS  per-row input buffer read enable.
- `in_rd_addr_o`  out  ROWS*AW, AW=$clog2(K_MAX)  per-row read address; row r occupies bits [r*AW +: AW].
- `w_rd_en_o`  out  COLS  per-column weight buffer read enable.
- `w_rd_addr_o`  out  COLS*AW  per-column read address; column c occupies bits [c*AW +: AW].
- `in_valid_o`  out  ROWS  `input_valid` into the array's left-edge PEs.
- `w_valid_o`  out  COLS  `weight_valid` into the array's top-edge PEs.
- `busy_o`  out  1  high in FEED, DRAIN and DONE.
- `done_o`  out  1  one-cycle tile-complete pulse.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - `cmd_ready_o`=1.
  - On handshake, latch K = min(`cmd_k_i`, K_MAX) and clear the counter t.
  - If K>0, go to FEED; if K=0, go to DONE.
- **FEED**
  - t increments every cycle from 0.
  - `in_rd_en_o[r]` = (t ≥ r) & (t < r+K). Address for row r = t−r when enabled, 0 otherwise.
  - Columns use the same rule with c in place of r.
  - Leave FEED after F = K + max(ROWS,COLS) − 1 cycles (t = F−1 is the last FEED cycle), then go to DRAIN with t cleared.
- **DRAIN**
  - All read enables are 0.
  - The state lasts D = BUF_LAT + MAC_LATENCY + ROWS + COLS − 2 cycles, then goes to DONE.
- **DONE**
  - `done_o`=1 for exactly one cycle, then IDLE.
- **Valid strobes**
  - `in_valid_o[r]` is `in_rd_en_o[r]` delayed by exactly BUF_LAT cycles; `w_valid_o[c]` likewise.
  - They follow the enables into DRAIN, which is why D includes BUF_LAT.
- **Abort**
  - `abort_i` sampled high in FEED, DRAIN or DONE: the next cycle is IDLE.
  - All enables are 0 and all valid delay lines are cleared in that same cycle. No `done_o`.
  - `abort_i` is ignored in IDLE, and takes priority over a command arriving in the same cycle.
- **Command sizing**
  - A K above K_MAX is clamped to K_MAX.
  - The command is not re-sampled until the next IDLE.
- **Counter width**
  - t counts up to max(F, D) − 1 and must be sized from the parameters, not from AW.

## Timing
- Reset values: state=IDLE, `cmd_ready_o`=1; every other output 0; delay lines cleared.
- Handshake at edge 0:
  - Cycle 1 is the first FEED cycle.
  - `in_rd_en_o[0]`=`w_rd_en_o[0]`=1 with address 0.
  - `in_valid_o[0]` rises in cycle 1+BUF_LAT.
- Cycle numbering: FEED occupies cycles 1..F, DRAIN occupies F+1..F+D, and `done_o` is high in cycle F+D+1.
- `cmd_ready_o` returns in cycle F+D+2. Back-to-back tiles therefore have a two-cycle gap after the last DRAIN cycle.
- K=0: `done_o` is high in cycle 1, `cmd_ready_o` in cycle 2, and no enables or valids are issued.
- Reset asserted mid-tile: outputs go to their reset values immediately, asynchronously.

## Structure
- Shared package `sa_ctrl_pkg` holds:
  - the state enum `sa_state_e`;
  - width helpers for KW, AW and counter width;
  - drain-length function `sa_drain_cycles(BUF_LAT, MAC_LATENCY, ROWS, COLS)`.
- One sub-module, `sa_valid_delay`: a parameterised N-bit, BUF_LAT-deep shift register with synchronous clear.
  - Instantiated twice: ROWS wide and COLS wide.

## Test plan
- ROWS=COLS=4, BUF_LAT=1, MAC_LATENCY=5, K=3 → F=6, D=12.
  - Row 2 enabled cycles 3–5, addresses 0,1,2.
  - `in_valid_o[2]` high cycles 4–6.
  - `done_o` in cycle 19 only; `cmd_ready_o` in cycle 20.
- K=0 → `done_o` in cycle 1; no read enable or valid ever high.
- `cmd_k_i`=K_MAX+5 with K_MAX=8 → row 0 addresses 0..7, then enable drops; F=11.
- `abort_i` in cycle 4 of the K=3 tile → cycle 5 is IDLE; all enables and valids 0; `cmd_ready_o`=1; no `done_o`.
- `rst_n` low mid-DRAIN → outputs reset immediately. A new K=2 command after release produces the skewed schedule from address 0.
- ROWS=4, COLS=2, K=2 → F=5; column 1 enabled cycles 2–3; row 3 enabled cycles 4–5.
